// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory access arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DM = 1'b1;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input grant logic; round-robin when MEM_ARB_ROUND_ROBIN_EN is defined, else fixed DM>IF
module rr_arb2
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic       clk,
  input  logic       rst_n,
`endif
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic win;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;

  // Pointer side wins ties; after any grant the other side gets priority.
  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    win   = req_i[ptr_q] ? ptr_q : ~ptr_q;
    if (en_i && (req_i != 2'b00)) begin
      gnt_o[win] = 1'b1;
      ptr_d      = ~win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= REQ_IF;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    gnt_o = 2'b00;
    win   = req_i[REQ_DM] ? REQ_DM : REQ_IF;
    if (en_i && (req_i != 2'b00)) begin
      gnt_o[win] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - shares one memory port between IF and DM; MEM_ARB_ROUND_ROBIN_EN selects round-robin
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  If_Req_i,
  input  logic [ADDR_WIDTH-1:0] If_Addr_i,
  output logic                  If_Ready_o,
  output logic                  If_Rvalid_o,
  input  logic                  Dm_Req_i,
  input  logic                  Dm_We_i,
  input  logic [ADDR_WIDTH-1:0] Dm_Addr_i,
  input  logic [DATA_WIDTH-1:0] Dm_Wdata_i,
  output logic                  Dm_Ready_o,
  output logic                  Dm_Rvalid_o,
  output logic [DATA_WIDTH-1:0] Rdata_o,
  output logic                  Err_o,
  output logic [ADDR_WIDTH-1:0] Mem_Address_o,
  output logic                  Mem_Write_Enable_o,
  output logic [DATA_WIDTH-1:0] Mem_Write_Data_o,
  input  logic [DATA_WIDTH-1:0] Mem_Read_Data_i,
  output logic                  Busy_o
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic                  rd_q, rd_d;
  logic                  owner_q, owner_d;

  logic       accept_win;
  logic       accept;
  logic [1:0] req;
  logic [1:0] gnt;

  // Gating with reset keeps Ready low while reset is held, like every other output.
  assign accept_win = reset && ((state_q == IDLE) || (state_q == RESP));
  assign req        = {Dm_Req_i, If_Req_i};
  assign accept     = gnt != 2'b00;

  rr_arb2 u_arb (
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .clk   (clk),
    .rst_n (reset),
`endif
    .en_i  (accept_win),
    .req_i (req),
    .gnt_o (gnt)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    err_d   = err_q;
    rd_d    = rd_q;
    owner_d = owner_q;

    case (state_q)
      IDLE:    state_d = accept ? ISSUE : IDLE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = accept ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      if (gnt[REQ_DM]) begin
        addr_d  = Dm_Addr_i;
        wdata_d = Dm_Wdata_i;
        err_d   = ALIGN_CHECK && misaligned(Dm_Addr_i[1:0]);
        we_d    = Dm_We_i && !(ALIGN_CHECK && misaligned(Dm_Addr_i[1:0]));
        rd_d    = !Dm_We_i;
        owner_d = REQ_DM;
      end else begin
        addr_d  = If_Addr_i;
        err_d   = ALIGN_CHECK && misaligned(If_Addr_i[1:0]);
        we_d    = 1'b0;
        rd_d    = 1'b1;
        owner_d = REQ_IF;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      owner_q <= REQ_IF;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      owner_q <= owner_d;
    end
  end

  assign If_Ready_o  = gnt[REQ_IF];
  assign Dm_Ready_o  = gnt[REQ_DM];

  // Payload registers only load on accept, so the bus holds its value between accesses.
  assign Mem_Address_o      = addr_q;
  assign Mem_Write_Data_o   = wdata_q;
  assign Mem_Write_Enable_o = (state_q == ISSUE) && we_q;

  assign If_Rvalid_o = (state_q == RESP) && (owner_q == REQ_IF);
  assign Dm_Rvalid_o = (state_q == RESP) && (owner_q == REQ_DM);
  assign Err_o       = (state_q == RESP) && err_q;
  assign Rdata_o     = ((state_q == RESP) && rd_q && !err_q) ? Mem_Read_Data_i : '0;
  assign Busy_o      = state_q != IDLE;

endmodule
